// File: rtl/procyon_rs_sched_pkg.sv
// Shared constants for the reservation-station scheduler slice.
// The opcode width matches the value used across the procyon core.
package procyon_rs_sched_pkg;

  localparam int PCYN_OPCODE_WIDTH = 8;
  localparam int PCYN_INSN_WIDTH   = 32;

endpackage

// File: rtl/procyon_rs_oldest_picker.sv
// Combinational max-age arbiter: among the candidate entries, picks the one
// with the largest age and returns it as one-hot, as an index, and with its age.
// Equal ages resolve toward the lowest index because only a strictly greater
// age displaces the current best.
module procyon_rs_oldest_picker #(
  parameter int DEPTH     = 16,
  parameter int AGE_WIDTH = 4,
  parameter int IDX_WIDTH = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]     candidates,
  input  logic [AGE_WIDTH-1:0] ages [0:DEPTH-1],
  output logic [DEPTH-1:0]     winner,
  output logic [IDX_WIDTH-1:0] winner_idx,
  output logic [AGE_WIDTH-1:0] winner_age,
  output logic                 valid
);

  // Scan all entries, keeping the oldest candidate seen so far
  always_comb begin
    valid      = 1'b0;
    winner_idx = '0;
    winner_age = '0;
    winner     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (candidates[i] && (!valid || (ages[i] > winner_age))) begin
        valid      = 1'b1;
        winner_idx = IDX_WIDTH'(i);
        winner_age = ages[i];
      end
    end
    if (valid) winner[winner_idx] = 1'b1;
  end

endmodule

// File: rtl/procyon_rs_sched.sv
// Reservation-station scheduler: grants empty entries to the dispatcher,
// steers the following dispatch payload to the granted entry, and issues the
// oldest ready entry into a one-deep register in front of the functional unit.
module procyon_rs_sched
  import procyon_rs_sched_pkg::*;
#(
  parameter int OPTN_DATA_WIDTH    = 32,
  parameter int OPTN_ADDR_WIDTH    = 32,
  parameter int OPTN_ROB_IDX_WIDTH = 5,
  parameter int OPTN_RS_DEPTH      = 16,
  parameter int RS_IDX_WIDTH       = $clog2(OPTN_RS_DEPTH)
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          i_flush,
  input  logic [OPTN_RS_DEPTH-1:0]      i_entry_empty,
  input  logic [OPTN_RS_DEPTH-1:0]      i_entry_ready,
  input  logic [RS_IDX_WIDTH-1:0]       i_entry_age      [0:OPTN_RS_DEPTH-1],
  input  logic [PCYN_OPCODE_WIDTH-1:0]  i_entry_opcode   [0:OPTN_RS_DEPTH-1],
  input  logic [OPTN_ADDR_WIDTH-1:0]    i_entry_iaddr    [0:OPTN_RS_DEPTH-1],
  input  logic [PCYN_INSN_WIDTH-1:0]    i_entry_insn     [0:OPTN_RS_DEPTH-1],
  input  logic [OPTN_ROB_IDX_WIDTH-1:0] i_entry_tag      [0:OPTN_RS_DEPTH-1],
  input  logic [OPTN_DATA_WIDTH-1:0]    i_entry_src_data [0:OPTN_RS_DEPTH-1][0:1],
  input  logic                          i_rs_reserve_en,
  input  logic                          i_rs_dispatch_en,
  output logic                          o_rs_stall,
  output logic [OPTN_RS_DEPTH-1:0]      o_reserve_en,
  output logic [OPTN_RS_DEPTH-1:0]      o_dispatch_en,
  output logic                          o_dispatching,
  output logic [OPTN_RS_DEPTH-1:0]      o_issue_en,
  output logic                          o_issuing,
  output logic [RS_IDX_WIDTH-1:0]       o_rs_issue_entry_age,
  input  logic                          i_fu_stall,
  output logic                          o_fu_valid,
  output logic [PCYN_OPCODE_WIDTH-1:0]  o_fu_opcode,
  output logic [OPTN_ADDR_WIDTH-1:0]    o_fu_iaddr,
  output logic [PCYN_INSN_WIDTH-1:0]    o_fu_insn,
  output logic [OPTN_DATA_WIDTH-1:0]    o_fu_src_data [0:1],
  output logic [OPTN_ROB_IDX_WIDTH-1:0] o_fu_tag
);

  logic                     reserved_vld_r;
  logic [RS_IDX_WIDTH-1:0]  reserved_idx_r;
  logic [RS_IDX_WIDTH-1:0]  reserve_idx;
  logic                     reserve_go;
  logic                     issue_free;
  logic                     issue_go;
  logic [OPTN_RS_DEPTH-1:0] pick_onehot;
  logic [RS_IDX_WIDTH-1:0]  pick_idx;
  logic [RS_IDX_WIDTH-1:0]  pick_age;
  logic                     pick_valid;

  // Stall whenever no entry is empty; an entry freed by issue this cycle
  // only shows up as empty on the next cycle.
  assign o_rs_stall = ~|i_entry_empty;
  assign reserve_go = i_rs_reserve_en & ~o_rs_stall & ~i_flush;

  // The issue register can take a new op when empty or being drained
  assign issue_free = ~o_fu_valid | ~i_fu_stall;
  assign issue_go   = pick_valid & issue_free & ~i_flush;

  // Lowest-index empty entry gets the reservation
  always_comb begin
    reserve_idx  = '0;
    o_reserve_en = '0;
    for (int i = OPTN_RS_DEPTH - 1; i >= 0; i--) begin
      if (i_entry_empty[i]) reserve_idx = RS_IDX_WIDTH'(i);
    end
    if (reserve_go) o_reserve_en[reserve_idx] = 1'b1;
  end

  // Dispatch payload goes to the entry reserved on the previous cycle
  always_comb begin
    o_dispatching = i_rs_dispatch_en & reserved_vld_r & ~i_flush;
    o_dispatch_en = '0;
    if (o_dispatching) o_dispatch_en[reserved_idx_r] = 1'b1;
  end

  // Remember which entry was granted so the next-cycle dispatch can find it
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      reserved_vld_r <= 1'b0;
      reserved_idx_r <= '0;
    end else begin
      reserved_vld_r <= reserve_go;
      if (reserve_go) reserved_idx_r <= reserve_idx;
    end
  end

  procyon_rs_oldest_picker #(
    .DEPTH     (OPTN_RS_DEPTH),
    .AGE_WIDTH (RS_IDX_WIDTH),
    .IDX_WIDTH (RS_IDX_WIDTH)
  ) oldest_picker (
    .candidates (i_entry_ready & ~i_entry_empty),
    .ages       (i_entry_age),
    .winner     (pick_onehot),
    .winner_idx (pick_idx),
    .winner_age (pick_age),
    .valid      (pick_valid)
  );

  assign o_issue_en           = issue_go ? pick_onehot : '0;
  assign o_issuing            = issue_go;
  assign o_rs_issue_entry_age = issue_go ? pick_age : '0;

  // Issue register valid: filled on issue, drained when the FU accepts, cleared on flush
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      o_fu_valid <= 1'b0;
    end else if (i_flush) begin
      o_fu_valid <= 1'b0;
    end else if (issue_go) begin
      o_fu_valid <= 1'b1;
    end else if (issue_free) begin
      o_fu_valid <= 1'b0;
    end
  end

  // Issue register payload captures the winner and otherwise holds
  always_ff @(posedge clk) begin
    if (issue_go) begin
      o_fu_opcode      <= i_entry_opcode[pick_idx];
      o_fu_iaddr       <= i_entry_iaddr[pick_idx];
      o_fu_insn        <= i_entry_insn[pick_idx];
      o_fu_tag         <= i_entry_tag[pick_idx];
      o_fu_src_data[0] <= i_entry_src_data[pick_idx][0];
      o_fu_src_data[1] <= i_entry_src_data[pick_idx][1];
    end
  end

endmodule

// File: tb/tb_procyon_rs_sched.sv
// Directed testbench for procyon_rs_sched: reserve/dispatch steering,
// oldest-first issue, FU stall hold, full-RS stall, flush and async reset.
module tb_procyon_rs_sched;
  import procyon_rs_sched_pkg::*;

  localparam int DEPTH = 16;
  localparam int IDXW  = 4;

  logic              clk;
  logic              n_rst;
  logic              flush;
  logic [DEPTH-1:0]  entry_empty;
  logic [DEPTH-1:0]  entry_ready;
  logic [IDXW-1:0]   entry_age      [0:DEPTH-1];
  logic [PCYN_OPCODE_WIDTH-1:0] entry_opcode [0:DEPTH-1];
  logic [31:0]       entry_iaddr    [0:DEPTH-1];
  logic [PCYN_INSN_WIDTH-1:0] entry_insn [0:DEPTH-1];
  logic [4:0]        entry_tag      [0:DEPTH-1];
  logic [31:0]       entry_src_data [0:DEPTH-1][0:1];
  logic              reserve_en;
  logic              dispatch_en;
  logic              fu_stall;

  logic              rs_stall;
  logic [DEPTH-1:0]  reserve_out;
  logic [DEPTH-1:0]  dispatch_out;
  logic              dispatching;
  logic [DEPTH-1:0]  issue_out;
  logic              issuing;
  logic [IDXW-1:0]   issue_age;
  logic              fu_valid;
  logic [PCYN_OPCODE_WIDTH-1:0] fu_opcode;
  logic [31:0]       fu_iaddr;
  logic [PCYN_INSN_WIDTH-1:0] fu_insn;
  logic [31:0]       fu_src_data [0:1];
  logic [4:0]        fu_tag;

  int vector_count = 0;
  int miss_count   = 0;

  procyon_rs_sched dut (
    .clk                  (clk),
    .n_rst                (n_rst),
    .i_flush              (flush),
    .i_entry_empty        (entry_empty),
    .i_entry_ready        (entry_ready),
    .i_entry_age          (entry_age),
    .i_entry_opcode       (entry_opcode),
    .i_entry_iaddr        (entry_iaddr),
    .i_entry_insn         (entry_insn),
    .i_entry_tag          (entry_tag),
    .i_entry_src_data     (entry_src_data),
    .i_rs_reserve_en      (reserve_en),
    .i_rs_dispatch_en     (dispatch_en),
    .o_rs_stall           (rs_stall),
    .o_reserve_en         (reserve_out),
    .o_dispatch_en        (dispatch_out),
    .o_dispatching        (dispatching),
    .o_issue_en           (issue_out),
    .o_issuing            (issuing),
    .o_rs_issue_entry_age (issue_age),
    .i_fu_stall           (fu_stall),
    .o_fu_valid           (fu_valid),
    .o_fu_opcode          (fu_opcode),
    .o_fu_iaddr           (fu_iaddr),
    .o_fu_insn            (fu_insn),
    .o_fu_src_data        (fu_src_data),
    .o_fu_tag             (fu_tag)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vector_count++;
    if (observed !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic res, input logic disp, input logic fl, input logic stall);
    reserve_en  = res;
    dispatch_en = disp;
    flush       = fl;
    fu_stall    = stall;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_rst       = 1'b0;
    entry_empty = '1;
    entry_ready = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_age[i]         = '0;
      entry_opcode[i]      = PCYN_OPCODE_WIDTH'(8'h40 + i);
      entry_iaddr[i]       = 32'h0000_1000 + 32'(4 * i);
      entry_insn[i]        = 32'hABC0_0000 + 32'(i);
      entry_tag[i]         = 5'(i + 10);
      entry_src_data[i][0] = 32'(i * 256);
      entry_src_data[i][1] = 32'hFFFF_0000 | 32'(i);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset state
    #12;
    checkOutput("rst_fu_valid", 64'(fu_valid), 64'd0);
    checkOutput("rst_issue_en", 64'(issue_out), 64'h0);
    checkOutput("rst_reserve_en", 64'(reserve_out), 64'h0);
    checkOutput("rst_dispatch_en", 64'(dispatch_out), 64'h0);
    checkOutput("rst_stall", 64'(rs_stall), 64'd0);
    @(negedge clk);
    n_rst = 1'b1;
    tick();

    // Reserve then dispatch, overlapping with a second reserve
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("res0_reserve_en", 64'(reserve_out), 64'h0001);
    tick();
    entry_empty[0] = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("disp0_dispatch_en", 64'(dispatch_out), 64'h0001);
    checkOutput("disp0_dispatching", 64'(dispatching), 64'd1);
    checkOutput("res1_reserve_en", 64'(reserve_out), 64'h0002);
    tick();
    entry_empty[1] = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("disp1_dispatch_en", 64'(dispatch_out), 64'h0002);
    checkOutput("disp1_reserve_en", 64'(reserve_out), 64'h0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("stray_dispatch_en", 64'(dispatch_out), 64'h0);
    checkOutput("stray_dispatching", 64'(dispatching), 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Oldest-first issue: entries 3,7,9 with ages 2,5,1
    entry_age[3] = 4'd2;
    entry_age[7] = 4'd5;
    entry_age[9] = 4'd1;
    entry_empty  = 16'hFD74;
    entry_ready  = 16'h0288;
    #1;
    checkOutput("pick7_issue_en", 64'(issue_out), 64'h0080);
    checkOutput("pick7_age", 64'(issue_age), 64'd5);
    checkOutput("pick7_issuing", 64'(issuing), 64'd1);
    tick();
    checkOutput("fu7_valid", 64'(fu_valid), 64'd1);
    checkOutput("fu7_tag", 64'(fu_tag), 64'd17);
    checkOutput("fu7_opcode", 64'(fu_opcode), 64'h47);
    checkOutput("fu7_src1", 64'(fu_src_data[1]), 64'hFFFF_0007);

    // FU stall holds the issue register for three cycles
    entry_ready = 16'h0208;
    entry_empty = 16'hFDF4;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      checkOutput("stall_issue_en", 64'(issue_out), 64'h0);
      checkOutput("stall_issuing", 64'(issuing), 64'd0);
      tick();
      checkOutput("stall_fu_valid", 64'(fu_valid), 64'd1);
      checkOutput("stall_fu_tag", 64'(fu_tag), 64'd17);
      checkOutput("stall_fu_iaddr", 64'(fu_iaddr), 64'h101C);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("unstall_issue_en", 64'(issue_out), 64'h0008);
    checkOutput("unstall_age", 64'(issue_age), 64'd2);
    tick();
    checkOutput("fu3_tag", 64'(fu_tag), 64'd13);
    checkOutput("fu3_insn", 64'(fu_insn), 64'hABC0_0003);

    // Equal ages between 9 and 12 resolve toward the lower index
    entry_age[12] = 4'd1;
    entry_ready   = 16'h1200;
    entry_empty   = 16'hEDFC;
    #1;
    checkOutput("tie_issue_en", 64'(issue_out), 64'h0200);
    checkOutput("tie_age", 64'(issue_age), 64'd1);
    tick();
    checkOutput("fu9_tag", 64'(fu_tag), 64'd19);
    checkOutput("fu9_src0", 64'(fu_src_data[0]), 64'h0900);
    entry_ready = '0;
    entry_empty = '1;
    #1;
    checkOutput("idle_issue_en", 64'(issue_out), 64'h0);
    tick();
    checkOutput("drain_fu_valid", 64'(fu_valid), 64'd0);

    // Only entry 15 empty, then full
    entry_empty = 16'h8000;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("last_reserve_en", 64'(reserve_out), 64'h8000);
    checkOutput("last_stall", 64'(rs_stall), 64'd0);
    tick();
    entry_empty = 16'h0000;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("full_stall", 64'(rs_stall), 64'd1);
    checkOutput("full_reserve_en", 64'(reserve_out), 64'h0);
    checkOutput("full_dispatch_en", 64'(dispatch_out), 64'h8000);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Flush with a valid issue register and a pending reservation
    for (int i = 0; i < DEPTH; i++) entry_age[i] = '0;
    entry_age[0] = 4'd3;
    entry_empty  = 16'hFFFE;
    entry_ready  = 16'h0001;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("pre_flush_reserve_en", 64'(reserve_out), 64'h0002);
    checkOutput("pre_flush_issue_en", 64'(issue_out), 64'h0001);
    tick();
    checkOutput("pre_flush_fu_valid", 64'(fu_valid), 64'd1);
    entry_empty = 16'hFFFC;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("flush_reserve_en", 64'(reserve_out), 64'h0);
    checkOutput("flush_dispatch_en", 64'(dispatch_out), 64'h0);
    checkOutput("flush_issue_en", 64'(issue_out), 64'h0);
    checkOutput("flush_issuing", 64'(issuing), 64'd0);
    tick();
    checkOutput("post_flush_fu_valid", 64'(fu_valid), 64'd0);
    entry_ready = '0;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("post_flush_dispatch_en", 64'(dispatch_out), 64'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    // Asynchronous reset in the middle of an issue
    entry_age[5] = 4'd7;
    entry_empty  = 16'hFFDF;
    entry_ready  = 16'h0020;
    #1;
    checkOutput("pick5_issue_en", 64'(issue_out), 64'h0020);
    tick();
    checkOutput("fu5_valid", 64'(fu_valid), 64'd1);
    #3;
    n_rst = 1'b0;
    #1;
    checkOutput("async_rst_fu_valid", 64'(fu_valid), 64'd0);
    @(negedge clk);
    n_rst = 1'b1;
    tick();
    checkOutput("post_rst_fu_valid", 64'(fu_valid), 64'd1);
    checkOutput("post_rst_fu_tag", 64'(fu_tag), 64'd15);

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
    $finish;
  end

endmodule
